mem_ctrl: RTL and testbench

- Sits between the pipeline and the single external byte-wide RAM port.
- Arbitrates instruction-fetch (IF) and load/store (MEM stage) requests onto that one port.
- Serialises each 1/2/4-byte access into byte cycles and assembles or splits little-endian words.
- Signals completion with one-cycle done pulses; the pipeline controller derives its stalls from these.

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/mem_ctrl_if.sv | 27 ++
 rtl/mem_ctrl_arb.sv | 22 ++
 rtl/mem_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for mem_ctrl: FSM states, grant IDs and access-length codes.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    typedef enum logic {GntIf, GntMem} gnt_e;

    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd2;

    // Code 3 is illegal and is served as a word access.
    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LenByte: return 3'd1;
            LenHalf: return 3'd2;
            LenWord: return 3'd4;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline-side bus of mem_ctrl: fetch and load/store request/done handshakes.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_done;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_len;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        input  if_done, if_inst, mem_done, mem_rdata
    );

    modport slave (
        input  if_req, if_addr, if_flush, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
        output if_done, if_inst, mem_done, mem_rdata
    );
endinterface

// File: rtl/mem_ctrl_arb.sv
// Combinational IF/MEM arbiter; MEM has priority unless it also won the previous grant.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic if_req_i,
    input  logic mem_req_i,
    input  logic if_flush_i,
    input  logic last_mem_i,
    output logic gnt_valid_o,
    output gnt_e gnt_id_o
);
    logic if_ok;

    always_comb begin
        if_ok       = if_req_i && !if_flush_i;
        gnt_valid_o = if_ok || mem_req_i;
        gnt_id_o    = GntMem;
        if (if_ok && (!mem_req_i || last_mem_i)) begin
            gnt_id_o = GntIf;
        end
    end
endmodule

// File: rtl/mem_ctrl.sv
// Serialises fetch and load/store accesses onto a byte-wide RAM port.
// Define MEM_CTRL_IBUF_EN to add a one-entry fetch buffer that bypasses RAM on a hit.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_ctrl_if.slave         bus,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              busy
);
    state_e            state_q, state_d;
    gnt_e              gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        len_q, len_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic              last_mem_q, last_mem_d;
    logic              cancel_q, cancel_d;

    logic       gnt_valid;
    gnt_e       gnt_id;
    logic [1:0] lane;
    logic [2:0] rd_idx;
    logic       if_done_w;

`ifdef MEM_CTRL_IBUF_EN
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [31:0]       buf_word_q, buf_word_d;
`endif

    mem_ctrl_arb u_arb (
        .if_req_i    (bus.if_req),
        .mem_req_i   (bus.mem_req),
        .if_flush_i  (bus.if_flush),
        .last_mem_i  (last_mem_q),
        .gnt_valid_o (gnt_valid),
        .gnt_id_o    (gnt_id)
    );

    // A flush in the done cycle itself still suppresses the pulse.
    assign if_done_w = (state_q == StDone) && (gnt_q == GntIf) && !cancel_q && !bus.if_flush;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        base_d     = base_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        last_mem_d = last_mem_q;
        cancel_d   = cancel_q;
        lane       = 2'(cnt_q - 3'd1);
`ifdef MEM_CTRL_IBUF_EN
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_word_d  = buf_word_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    gnt_d      = gnt_id;
                    last_mem_d = (gnt_id == GntMem);
                    cnt_d      = '0;
                    asm_d      = '0;
                    cancel_d   = 1'b0;
                    if (gnt_id == GntMem) begin
                        base_d  = bus.mem_addr;
                        len_d   = len_bytes(bus.mem_len);
                        wdata_d = bus.mem_wdata;
                        state_d = bus.mem_we ? StWr : StRd;
                    end else begin
                        base_d  = bus.if_addr;
                        len_d   = 3'd4;
                        state_d = StRd;
                    end
`ifdef MEM_CTRL_IBUF_EN
                    if (gnt_id == GntMem && bus.mem_we) begin
                        buf_valid_d = 1'b0;
                    end
                    if (gnt_id == GntIf && buf_valid_q && bus.if_addr == buf_addr_q) begin
                        state_d = StDone;
                        asm_d   = buf_word_q;
                    end
`endif
                end
            end
            StRd: begin
                // RAM data lags its address by one cycle, so lane cnt-1 lands now.
                if (cnt_q != 3'd0) begin
                    asm_d[{lane, 3'b000} +: 8] = ram_din;
                end
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q) begin
                    state_d = StDone;
                end
            end
            StWr: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == len_q - 3'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
`ifdef MEM_CTRL_IBUF_EN
                if (if_done_w) begin
                    buf_valid_d = 1'b1;
                    buf_addr_d  = base_q;
                    buf_word_d  = asm_q;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        if (state_q != StIdle && gnt_q == GntIf && bus.if_flush) begin
            cancel_d = 1'b1;
        end
    end

    always_comb begin
        ram_addr = '0;
        ram_wr   = 1'b0;
        ram_dout = '0;
        rd_idx   = (cnt_q < len_q) ? cnt_q : len_q - 3'd1;
        if (state_q == StRd) begin
            ram_addr = base_q + ADDR_W'(rd_idx);
        end else if (state_q == StWr) begin
            ram_addr = base_q + ADDR_W'(cnt_q);
            ram_wr   = 1'b1;
            ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        end
        busy          = (state_q != StIdle);
        bus.if_done   = if_done_w;
        bus.mem_done  = (state_q == StDone) && (gnt_q == GntMem);
        bus.if_inst   = asm_q;
        bus.mem_rdata = asm_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            gnt_q      <= GntIf;
            base_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            last_mem_q <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            base_q     <= base_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            last_mem_q <= last_mem_d;
            cancel_q   <= cancel_d;
        end
    end

`ifdef MEM_CTRL_IBUF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_word_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_word_q  <= buf_word_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized traffic vs a byte-array model.
`timescale 1ns/1ps
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // RAM model (aliased on 12 address bits) and the reference view of its contents.
    logic [7:0]  mem     [4096];
    logic [7:0]  ref_mem [4096];
    bit          m_buf_valid = 1'b0;
    logic [31:0] m_buf_addr  = '0;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .ram_addr (ram_addr),
        .ram_wr   (ram_wr),
        .ram_dout (ram_dout),
        .ram_din  (ram_din),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= mem[ram_addr[11:0]];
        if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one access from IDLE (called at a negedge) and check it end to end.
    task automatic run_access(input bit is_if, input bit we, input logic [1:0] len,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int flush_cyc, input string tag);
        int          n;
        int          exp_done;
        int          done_c;
        bit          hit;
        logic [31:0] exp_data;
        logic [31:0] got;
        logic [31:0] obs_addr [9];
        logic        obs_wr   [9];
        logic [7:0]  obs_dout [9];
        n = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        hit = 1'b0;
`ifdef MEM_CTRL_IBUF_EN
        hit = is_if && m_buf_valid && (m_buf_addr == addr);
`endif
        exp_done = hit ? 1 : (we ? n + 1 : n + 2);
        exp_data = '0;
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            a = addr + 32'(i);
            exp_data[8*i +: 8] = ref_mem[a[11:0]];
        end
        if (is_if) begin
            bus.if_req  = 1'b1;
            bus.if_addr = addr;
        end else begin
            bus.mem_req   = 1'b1;
            bus.mem_we    = we;
            bus.mem_len   = len;
            bus.mem_addr  = addr;
            bus.mem_wdata = wdata;
        end
        done_c = -1;
        got    = '0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                obs_addr[c] = ram_addr;
                obs_wr[c]   = ram_wr;
                obs_dout[c] = ram_dout;
            end
            if (is_if ? bus.if_done : bus.mem_done) begin
                done_c = c;
                got    = is_if ? bus.if_inst : bus.mem_rdata;
                break;
            end
            if (c == flush_cyc) begin
                bus.if_flush = 1'b1;
                bus.if_req   = 1'b0;
            end else begin
                bus.if_flush = 1'b0;
            end
            if (flush_cyc > 0 && c > flush_cyc && !busy) break;
        end
        bus.if_req   = 1'b0;
        bus.mem_req  = 1'b0;
        bus.if_flush = 1'b0;
        if (done_c > 0) @(negedge clk);

        if (hit) begin
            chk($sformatf("%s_hit_nowr", tag), 32'(obs_wr[1]), 32'd0);
        end else begin
            for (int i = 0; i < n; i++) begin
                chk($sformatf("%s_addr%0d", tag, i), obs_addr[i+1], addr + 32'(i));
                chk($sformatf("%s_wr%0d", tag, i), 32'(obs_wr[i+1]), 32'(we));
                if (we) chk($sformatf("%s_dout%0d", tag, i), 32'(obs_dout[i+1]),
                            32'(wdata[8*i +: 8]));
            end
            if (!we) chk($sformatf("%s_hold", tag), obs_addr[n+1], addr + 32'(n - 1));
        end
        if (flush_cyc > 0) begin
            chk($sformatf("%s_nodone", tag), 32'(done_c), 32'hFFFF_FFFF);
        end else begin
            chk($sformatf("%s_donecyc", tag), 32'(done_c), 32'(exp_done));
            if (!we) chk($sformatf("%s_data", tag), got, exp_data);
        end

        if (we) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] a;
                a = addr + 32'(i);
                ref_mem[a[11:0]] = wdata[8*i +: 8];
            end
            m_buf_valid = 1'b0;
        end
        if (is_if && flush_cyc == 0) begin
            m_buf_valid = 1'b1;
            m_buf_addr  = addr;
        end
    endtask

    initial begin
        int          ev_id [3];
        int          ev_c  [3];
        int          k;
        logic [31:0] if_word;
        logic [31:0] w;

        for (int i = 0; i < 4096; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[12'h100 + 12'(i)]     = 8'(8'h11 * (i + 1));
            ref_mem[12'h100 + 12'(i)] = 8'(8'h11 * (i + 1));
        end
        bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
        bus.mem_req = 0; bus.mem_we = 0; bus.mem_len = 0; bus.mem_addr = 0; bus.mem_wdata = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_mem_done", 32'(bus.mem_done), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_inst", bus.if_inst, 32'd0);

        // Both requesters pending out of reset: MEM, then IF, then MEM.
        if_word = {ref_mem[12'h503], ref_mem[12'h502], ref_mem[12'h501], ref_mem[12'h500]};
        bus.mem_req = 1; bus.mem_we = 0; bus.mem_len = 2'd2; bus.mem_addr = 32'h100;
        bus.if_req = 1; bus.if_addr = 32'h500;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin ev_id[i] = -1; ev_c[i] = -1; end
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.mem_done || bus.if_done) begin
                ev_id[k] = bus.mem_done ? 1 : 0;
                ev_c[k]  = c;
                if (bus.if_done) chk("arb_inst", bus.if_inst, if_word);
                k++;
                if (k == 3) break;
            end
        end
        bus.mem_req = 0; bus.if_req = 0;
        @(negedge clk);
        chk("arb_c0", 32'(ev_c[0]), 32'd6);
        chk("arb_id0", 32'(ev_id[0]), 32'd1);
        chk("arb_c1", 32'(ev_c[1]), 32'd13);
        chk("arb_id1", 32'(ev_id[1]), 32'd0);
        chk("arb_c2", 32'(ev_c[2]), 32'd20);
        chk("arb_id2", 32'(ev_id[2]), 32'd1);
        m_buf_valid = 1'b1;
        m_buf_addr  = 32'h500;

        run_access(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 0, "lw100");
        chk("lw100_value", bus.mem_rdata, 32'h4433_2211);
        run_access(1'b0, 1'b1, 2'd1, 32'h202, 32'hDEAD_BEEF, 0, "sh202");
        run_access(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 3, "fetch_flush");
        run_access(1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 0, "fetch40");
        run_access(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0, 0, "lw_wrap");

        // Flush while idle must block the fetch grant for that cycle.
        bus.if_addr = 32'h80; bus.if_req = 1; bus.if_flush = 1;
        @(negedge clk);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        bus.if_req = 0; bus.if_flush = 0;
        run_access(1'b1, 1'b0, 2'd0, 32'h80, 32'h0, 0, "fetch80");

        for (int r = 0; r < 24; r++) begin
            int          kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                a = (($urandom_range(0, 2)) == 0) ? 32'h800 : 32'h804;
                run_access(1'b1, 1'b0, 2'd0, a, 32'h0, 0, $sformatf("rnd%0d_if", r));
            end else begin
                a = 32'h800 + 32'($urandom_range(0, 15));
                run_access(1'b0, kind == 2, 2'($urandom_range(0, 3)), a, $urandom, 0,
                           $sformatf("rnd%0d_%s", r, kind == 2 ? "st" : "ld"));
            end
        end

        // Reset during the second byte of a word store truncates it.
        w = $urandom;
        bus.mem_req = 1; bus.mem_we = 1; bus.mem_len = 2'd2; bus.mem_addr = 32'h600;
        bus.mem_wdata = w;
        @(negedge clk);
        chk("sw_rst_c1_addr", ram_addr, 32'h600);
        chk("sw_rst_c1_dout", 32'(ram_dout), 32'(w[7:0]));
        @(negedge clk);
        chk("sw_rst_c2_addr", ram_addr, 32'h601);
        rst = 1'b0;
        #1;
        chk("mid_rst_ram_addr", ram_addr, 32'd0);
        chk("mid_rst_ram_wr", 32'(ram_wr), 32'd0);
        chk("mid_rst_ram_dout", 32'(ram_dout), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mem_done", 32'(bus.mem_done), 32'd0);
        chk("mid_rst_rdata", bus.mem_rdata, 32'd0);
        bus.mem_req = 0; bus.mem_we = 0;
        @(negedge clk);
        rst = 1'b1;
        ref_mem[12'h600] = w[7:0];
        m_buf_valid = 1'b0;
        @(negedge clk);
        run_access(1'b0, 1'b0, 2'd2, 32'h600, 32'h0, 0, "lw_trunc");

        run_access(1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 0, "refetch40_a");
        run_access(1'b1, 1'b0, 2'd0, 32'h40, 32'h0, 0, "refetch40_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
